matrix_scalar_result_collector: RTL and testbench
=================================================

# matrix_scalar_result_collector

Downstream stage of the matrix-scalar multiplier. The multiplier has no backpressure: its result and valid flag pass straight through in the same cycle. This block absorbs that stream into a small FIFO, tags each element with its (row, col) position inside an ROWS×COLS matrix, and re-emits it on a valid/ready interface for the writeback stage. It also gives the upstream sequencer an almost-full hint and a sticky overflow flag for dropped results.

## Interface
- DATA_W, 32, element width; matches the multiplier result.
- ROWS, 4, matrix rows, ≥1.
- COLS, 4, matrix columns, ≥1.
- FIFO_DEPTH, 8, entries; power of two, ≥2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush: empties FIFO, zeroes counters, clears overflow.
- in_valid  in  1  result valid from the multiplier.
- in_data  in  DATA_W  result from the multiplier.
- almost_full  out  1  level ≥ FIFO_DEPTH-1; upstream stalls issue on this.
- overflow  out  1  sticky; set when a result is dropped.
- out_valid  out  1  head element available.
- out_ready  in  1  consumer accepts head element.
- out_data  out  DATA_W  head element; 0 when out_valid=0.
- out_row  out  max(1,clog2(ROWS))  row index of the head element.
- out_col  out  max(1,clog2(COLS))  column index of the head element.
- out_last_col  out  1  head is the last element of its row (col==COLS-1), qualified by out_valid.
- out_last  out  1  head is the last element of the matrix, qualified by out_valid.
- level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- matrix_count  out  16  completed matrices popped; wraps at 2^16.

## Operation
- **Storage.** Circular FIFO built from a register array, write pointer, read pointer and occupancy counter. out_data is a combinational read of mem[rd_ptr], gated to 0 when empty.
- **Push** happens when in_valid=1 and either:
  - level<FIFO_DEPTH, or
  - level==FIFO_DEPTH and a pop occurs in the same cycle (the slot is reused).
- **Drop.** Otherwise in_valid=1 discards in_data, sets overflow, and leaves the FIFO state unchanged.
- **Pop.** Occurs when out_valid && out_ready.
- **Level update.** Push alone: +1. Pop alone: -1. Both: unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Position counters.** They advance on pop only; out_row/out_col always describe the head element.
  - col increments on each pop.
  - At col==COLS-1, col wraps to 0 and row increments.
  - At row==ROWS-1 with col==COLS-1, both wrap to 0 and matrix_count increments.
- **Degenerate sizes.**
  - COLS=1: out_last_col is 1 whenever out_valid=1.
  - ROWS=COLS=1: out_last is 1 whenever out_valid=1.
- **Priority.** rst > clear > push/pop.
  - clear=1 resets pointers, level, row, col and overflow.
  - clear=1 ignores any push or pop in the same cycle.
  - clear=1 does not reset matrix_count.
  - rst resets everything, including matrix_count.
- **Output stability.** While out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last* must not change.

## Timing
- **Reset values.** Every output is 0 after rst: out_valid, out_data, out_row, out_col, out_last_col, out_last, level, overflow, almost_full, matrix_count.
- **Latency.** Data pushed in cycle N is visible on out_valid/out_data in cycle N+1. There is no fall-through.
- **Throughput.** One push and one pop per cycle, sustained.
- **almost_full.** Combinational from level; updates in the cycle after the push/pop that changes level.
- **overflow.** Rises in the cycle after the dropped push. It stays high until rst or clear.
- **Combinational path.** out_ready → push enable is permitted only for the full-and-pop case. No other combinational path from inputs to outputs besides clear/rst being synchronous, i.e. none.
- **Reset mid-operation.** rst asserted during active transfers discards all contents. Outputs read 0 in the next cycle.

## Test plan
All scenarios use ROWS=2, COLS=3, FIFO_DEPTH=4.
- **Reset.** Drive random inputs, assert rst for 2 cycles → every output 0; level=0, overflow=0.
- **In-order stream.** out_ready=1, push 1..6 on consecutive cycles →
  - out_data 1..6, each one cycle after its push.
  - (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - out_last_col on values 3 and 6; out_last on 6.
  - matrix_count=1 afterwards.
- **Overflow.** out_ready=0, push 10,11,12,13,14 →
  - level=4 and almost_full=1 after 13.
  - 14 dropped; overflow=1 and stays 1.
  - Drain → 10,11,12,13 only.
- **Full with simultaneous push/pop.** level=4, push 20 while popping the head →
  - level stays 4, overflow stays 0.
  - 20 emerges fourth.
- **Backpressure.** Head=7 at (0,1), hold out_ready=0 for 5 cycles → out_data=7, out_row=0, out_col=1 stable throughout.
- **Clear mid-matrix.** After 4 pops with level=2 and overflow=1, assert clear together with in_valid=1 →
  - Next cycle: level=0, out_valid=0, row=col=0, overflow=0.
  - matrix_count unchanged.
  - The concurrent push is not stored.

Source files
------------

// File: rtl/matrix_scalar_result_collector.sv
// Result collector: absorbs a non-backpressured multiplier stream into a FIFO,
// tags each head element with its (row, col) matrix position and re-emits it on valid/ready.
module matrix_scalar_result_collector #(
  parameter int DATA_W     = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LW        = AW + 1,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              almost_full,
  output logic              overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              out_last_col,
  output logic              out_last,
  output logic [LW-1:0]     level,
  output logic [15:0]       matrix_count
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [15:0]       mcount_q, mcount_d;
  logic              ovf_q, ovf_d;

  logic full, push, pop, drop, at_last_col, at_last_row;

  assign out_valid   = (level_q != '0);
  assign full        = (level_q == LW'(FIFO_DEPTH));
  assign pop         = out_valid && out_ready;
  // A full FIFO only accepts when the head leaves in the same cycle.
  assign push        = in_valid && (!full || pop);
  assign drop        = in_valid && !push;
  assign at_last_col = (col_q == CW'(COLS - 1));
  assign at_last_row = (row_q == RW'(ROWS - 1));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    row_d    = row_q;
    col_d    = col_q;
    mcount_d = mcount_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      row_d    = '0;
      col_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (drop) ovf_d = 1'b1;
      if (pop) begin
        if (at_last_col) begin
          col_d = '0;
          if (at_last_row) begin
            row_d    = '0;
            mcount_d = mcount_q + 16'd1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      mcount_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mcount_q <= mcount_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: out_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_row      = row_q;
  assign out_col      = col_q;
  assign out_last_col = out_valid && at_last_col;
  assign out_last     = out_valid && at_last_col && at_last_row;
  assign level        = level_q;
  assign almost_full  = (level_q >= LW'(FIFO_DEPTH - 1));
  assign overflow     = ovf_q;
  assign matrix_count = mcount_q;

endmodule

// File: tb/tb_matrix_scalar_result_collector.sv
// Scoreboard bench: stimulus predicts accepted elements into a queue, a negedge monitor
// compares every DUT output against a queue-based reference of the FIFO/matrix behaviour.
module tb_matrix_scalar_result_collector;
  localparam int DW = 32, R = 2, C = 3, D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        almost_full, overflow, out_valid, out_last_col, out_last;
  logic [31:0] out_data;
  logic [0:0]  out_row;
  logic [1:0]  out_col;
  logic [2:0]  level;
  logic [15:0] matrix_count;

  matrix_scalar_result_collector #(.DATA_W(DW), .ROWS(R), .COLS(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .almost_full(almost_full), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last_col(out_last_col), .out_last(out_last), .level(level),
    .matrix_count(matrix_count)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int          mlevel = 0, spos = 0;
  logic [15:0] mmc = '0;
  bit          movf = 1'b0, started = 1'b0;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model, evaluated at the clock edge using the inputs being sampled.
  task automatic model();
    bit p, q;
    if (rst) begin
      mlevel = 0; spos = 0; mmc = '0; movf = 1'b0; exp_q.delete();
    end else if (clear) begin
      mlevel = 0; spos = 0; movf = 1'b0; exp_q.delete();
    end else begin
      p = (mlevel > 0) && out_ready;
      q = in_valid && ((mlevel < D) || p);
      if (p) begin
        if (spos % (R * C) == R * C - 1) mmc++;
        spos++;
      end
      if (q) exp_q.push_back(in_data);
      mlevel = mlevel + int'(q) - int'(p);
      if (in_valid && !q) movf = 1'b1;
    end
  endtask

  task automatic cyc(input bit iv, input logic [31:0] d, input bit rdy,
                     input bit cl = 1'b0, input bit rs = 1'b0);
    in_valid = iv; in_data = d; out_ready = rdy; clear = cl; rst = rs;
    @(posedge clk);
    model();
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("level", level, mlevel);
      chk("almost_full", almost_full, mlevel >= D - 1);
      chk("overflow", overflow, movf);
      chk("matrix_count", matrix_count, mmc);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("out_row", out_row, (spos % (R * C)) / C);
      chk("out_col", out_col, spos % C);
      if (exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last_col", out_last_col, (spos % C) == C - 1);
        chk("out_last", out_last, (spos % (R * C)) == R * C - 1);
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_data_idle", out_data, 0);
        chk("out_last_col_idle", out_last_col, 0);
        chk("out_last_idle", out_last, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs, held two cycles.
    cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1'b0, 1'b1);
    started = 1'b1;
    cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1'b0, 1'b1);
    cyc(0, 0, 0);

    // In-order stream, one matrix.
    for (int i = 1; i <= 6; i++) cyc(1, i, 1);
    repeat (3) cyc(0, 0, 1);

    // Overflow: fill, drop, hold, drain.
    cyc(0, 0, 0, 1'b1);
    for (int i = 10; i <= 14; i++) cyc(1, i, 0);
    repeat (3) cyc(0, 0, 0);
    repeat (6) cyc(0, 0, 1);

    // Full with simultaneous push and pop.
    cyc(0, 0, 0, 1'b1);
    for (int i = 21; i <= 24; i++) cyc(1, i, 0);
    cyc(1, 20, 1);
    repeat (6) cyc(0, 0, 1);

    // Backpressure on head 7 at (0,1).
    cyc(0, 0, 0, 1'b1);
    cyc(1, 6, 0);
    cyc(1, 7, 0);
    cyc(0, 0, 1);
    repeat (5) cyc(0, 0, 0);
    repeat (3) cyc(0, 0, 1);

    // Clear mid-matrix with level 2 and overflow set.
    cyc(0, 0, 0, 1'b1);
    for (int i = 30; i <= 33; i++) cyc(1, i, 0);
    cyc(1, 34, 0);
    cyc(1, 35, 1);
    cyc(1, 36, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 99, 0, 1'b1);
    repeat (3) cyc(0, 0, 0);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    repeat (8) cyc(0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
